// File: rtl/uram_rd_arb.sv
// Two-client read arbiter and response router for one SDP URAM/BRAM read port.
// Define URAM_RD_ARB_FIXED_PRIO_EN to let client 0 win every contention (client 1 may starve).
module uram_rd_arb #(
    parameter int ADDR_WIDTH  = 13,
    parameter int DATA_WIDTH  = 72,
    parameter int MEM_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_block,
    input  logic                  c0_rd_req,
    input  logic [ADDR_WIDTH-1:0] c0_rd_addr,
    output logic                  c0_rd_gnt,
    output logic                  c0_rd_vld,
    output logic [DATA_WIDTH-1:0] c0_rd_data,
    input  logic                  c1_rd_req,
    input  logic [ADDR_WIDTH-1:0] c1_rd_addr,
    output logic                  c1_rd_gnt,
    output logic                  c1_rd_vld,
    output logic [DATA_WIDTH-1:0] c1_rd_data,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  idle
);

    logic                   gnt0, gnt1, any_gnt;
    logic                   mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_WIDTH-1:0]  mem_rd_addr_q, mem_rd_addr_d;
    logic                   issue_id_q, issue_id_d;
    logic [MEM_LATENCY-1:0] tag_vld_q, tag_id_q;
    logic                   c0_rd_vld_q, c0_rd_vld_d;
    logic                   c1_rd_vld_q, c1_rd_vld_d;
    logic [DATA_WIDTH-1:0]  c0_rd_data_q, c0_rd_data_d;
    logic [DATA_WIDTH-1:0]  c1_rd_data_q, c1_rd_data_d;
    logic                   idle_q, idle_d;
`ifndef URAM_RD_ARB_FIXED_PRIO_EN
    logic                   last_gnt_q, last_gnt_d;
`endif

    // NOTE: every signal driven in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && !rd_block) begin
            if (c0_rd_req && c1_rd_req) begin
`ifdef URAM_RD_ARB_FIXED_PRIO_EN
                gnt0 = 1'b1;
`else
                gnt0 = last_gnt_q;
                gnt1 = ~last_gnt_q;
`endif
            end else begin
                gnt0 = c0_rd_req;
                gnt1 = c1_rd_req;
            end
        end
    end

    assign any_gnt = gnt0 | gnt1;

    // The last tag stage lines up with mem_dout; its id steers the data to one client.
    always_comb begin
        mem_rd_en_d   = any_gnt;
        mem_rd_addr_d = mem_rd_addr_q;
        issue_id_d    = issue_id_q;
        if (any_gnt) begin
            mem_rd_addr_d = gnt1 ? c1_rd_addr : c0_rd_addr;
            issue_id_d    = gnt1;
        end
`ifndef URAM_RD_ARB_FIXED_PRIO_EN
        last_gnt_d = any_gnt ? gnt1 : last_gnt_q;
`endif
        c0_rd_vld_d  = tag_vld_q[MEM_LATENCY-1] & ~tag_id_q[MEM_LATENCY-1];
        c1_rd_vld_d  = tag_vld_q[MEM_LATENCY-1] &  tag_id_q[MEM_LATENCY-1];
        c0_rd_data_d = c0_rd_vld_d ? mem_dout : c0_rd_data_q;
        c1_rd_data_d = c1_rd_vld_d ? mem_dout : c1_rd_data_q;
        idle_d       = ~mem_rd_en_q & ~(|tag_vld_q) & ~any_gnt;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
            issue_id_q    <= 1'b0;
            tag_vld_q     <= '0;
            tag_id_q      <= '0;
            c0_rd_vld_q   <= 1'b0;
            c1_rd_vld_q   <= 1'b0;
            c0_rd_data_q  <= '0;
            c1_rd_data_q  <= '0;
            idle_q        <= 1'b1;
`ifndef URAM_RD_ARB_FIXED_PRIO_EN
            last_gnt_q    <= 1'b1;
`endif
        end else begin
            mem_rd_en_q   <= mem_rd_en_d;
            mem_rd_addr_q <= mem_rd_addr_d;
            issue_id_q    <= issue_id_d;
            tag_vld_q[0]  <= mem_rd_en_q;
            tag_id_q[0]   <= issue_id_q;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
            c0_rd_vld_q   <= c0_rd_vld_d;
            c1_rd_vld_q   <= c1_rd_vld_d;
            c0_rd_data_q  <= c0_rd_data_d;
            c1_rd_data_q  <= c1_rd_data_d;
            idle_q        <= idle_d;
`ifndef URAM_RD_ARB_FIXED_PRIO_EN
            last_gnt_q    <= last_gnt_d;
`endif
        end
    end

    assign c0_rd_gnt   = gnt0;
    assign c1_rd_gnt   = gnt1;
    assign c0_rd_vld   = c0_rd_vld_q;
    assign c1_rd_vld   = c1_rd_vld_q;
    assign c0_rd_data  = c0_rd_data_q;
    assign c1_rd_data  = c1_rd_data_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_rd_addr = mem_rd_addr_q;
    assign idle        = idle_q;

endmodule

// File: tb/tb_uram_rd_arb.sv
// Directed bench for uram_rd_arb: behavioural fixed-latency memory plus per-scenario tasks.
// Honours URAM_RD_ARB_FIXED_PRIO_EN for the contention expectations.
module tb_uram_rd_arb;

    localparam int AW   = 13;
    localparam int DW   = 72;
    localparam int LAT  = 4;
    localparam int RESP = LAT + 2;
`ifdef URAM_RD_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, rd_block;
    logic          c0_rd_req, c1_rd_req;
    logic [AW-1:0] c0_rd_addr, c1_rd_addr;
    logic          c0_rd_gnt, c1_rd_gnt, c0_rd_vld, c1_rd_vld;
    logic [DW-1:0] c0_rd_data, c1_rd_data;
    logic          mem_rd_en, idle;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_dout;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    uram_rd_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .rd_block(rd_block),
        .c0_rd_req(c0_rd_req), .c0_rd_addr(c0_rd_addr), .c0_rd_gnt(c0_rd_gnt),
        .c0_rd_vld(c0_rd_vld), .c0_rd_data(c0_rd_data),
        .c1_rd_req(c1_rd_req), .c1_rd_addr(c1_rd_addr), .c1_rd_gnt(c1_rd_gnt),
        .c1_rd_vld(c1_rd_vld), .c1_rd_data(c1_rd_data),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_dout(mem_dout),
        .idle(idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mv(int a);
        if (a == 5) return 72'hA5;
        return {8'h5A, 32'hC0DE_0000 + 32'(a), 32'(a * 7)};
    endfunction

    // Memory: rd_en sampled at an edge, data visible LAT-1 edges later (NUM_PIPE = LAT-1).
    logic [DW-1:0] mem     [0:63];
    logic [DW-1:0] rd_pipe [0:LAT-1];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = mv(i);
        for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;
    end
    always @(posedge clk) begin
        if (mem_rd_en) rd_pipe[0] <= mem[mem_rd_addr[5:0]];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_dout = rd_pipe[LAT-1];

    // Response log: cycle index and data of every vld pulse.
    int            c0_cyc_q[$], c1_cyc_q[$];
    logic [DW-1:0] c0_dat_q[$], c1_dat_q[$];
    always @(negedge clk) begin
        if (c0_rd_vld === 1'b1) begin c0_cyc_q.push_back(cyc); c0_dat_q.push_back(c0_rd_data); end
        if (c1_rd_vld === 1'b1) begin c1_cyc_q.push_back(cyc); c1_dat_q.push_back(c1_rd_data); end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        c0_cyc_q.delete(); c0_dat_q.delete(); c1_cyc_q.delete(); c1_dat_q.delete();
    endtask

    task automatic test_reset();
        // rst still high here with both clients requesting
        #1;
        n_total++; if ({c0_rd_gnt, c1_rd_gnt} !== 2'b00) $display("FAIL reset_gnt: got %b want 00", {c0_rd_gnt, c1_rd_gnt}); else n_pass++;
        n_total++; if (mem_rd_en !== 1'b0) $display("FAIL reset_mem_rd_en: got %b want 0", mem_rd_en); else n_pass++;
        n_total++; if (mem_rd_addr !== '0) $display("FAIL reset_mem_rd_addr: got %h want 0", mem_rd_addr); else n_pass++;
        n_total++; if ({c0_rd_vld, c1_rd_vld} !== 2'b00) $display("FAIL reset_vld: got %b want 00", {c0_rd_vld, c1_rd_vld}); else n_pass++;
        n_total++; if (c0_rd_data !== '0) $display("FAIL reset_c0_data: got %h want 0", c0_rd_data); else n_pass++;
        n_total++; if (c1_rd_data !== '0) $display("FAIL reset_c1_data: got %h want 0", c1_rd_data); else n_pass++;
        n_total++; if (idle !== 1'b1) $display("FAIL reset_idle: got %b want 1", idle); else n_pass++;
        rst = 1'b0; c0_rd_req = 1'b0; c1_rd_req = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int t0;
        clear_log();
        c0_rd_req = 1'b1; c0_rd_addr = 13'd5;
        #1; t0 = cyc;
        n_total++; if ({c0_rd_gnt, c1_rd_gnt} !== 2'b10) $display("FAIL single_gnt: got %b want 10", {c0_rd_gnt, c1_rd_gnt}); else n_pass++;
        tick();
        c0_rd_req = 1'b0; c0_rd_addr = '0;
        n_total++; if (mem_rd_en !== 1'b1) $display("FAIL single_mem_rd_en: got %b want 1", mem_rd_en); else n_pass++;
        n_total++; if (mem_rd_addr !== 13'd5) $display("FAIL single_mem_rd_addr: got %h want 5", mem_rd_addr); else n_pass++;
        n_total++; if (idle !== 1'b0) $display("FAIL single_idle_busy: got %b want 0", idle); else n_pass++;
        repeat (RESP + 2) tick();
        n_total++;
        if (c0_cyc_q.size() != 1) $display("FAIL single_c0_count: got %0d want 1", c0_cyc_q.size());
        else if (c0_cyc_q[0] != t0 + RESP || c0_dat_q[0] !== 72'hA5)
            $display("FAIL single_c0_resp: got cycle %0d data %h want cycle %0d data a5", c0_cyc_q[0], c0_dat_q[0], t0 + RESP);
        else n_pass++;
        n_total++; if (c1_cyc_q.size() != 0) $display("FAIL single_c1_quiet: got %0d pulses want 0", c1_cyc_q.size()); else n_pass++;
        n_total++; if (c0_rd_data !== 72'hA5) $display("FAIL single_c0_hold: got %h want a5", c0_rd_data); else n_pass++;
        n_total++; if (idle !== 1'b1) $display("FAIL single_idle_back: got %b want 1", idle); else n_pass++;
    endtask

    task automatic test_contention();
        int t0, e0[$], e1[$];
        logic exp0;
        clear_log();
        rst = 1'b1; tick(); rst = 1'b0;
        c0_rd_req = 1'b1; c0_rd_addr = 13'd10;
        c1_rd_req = 1'b1; c1_rd_addr = 13'd20;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (i == 0) t0 = cyc;
            exp0 = FIXED ? 1'b1 : (i % 2 == 0);
            if (exp0) e0.push_back(t0 + i + RESP); else e1.push_back(t0 + i + RESP);
            n_total++;
            if ({c0_rd_gnt, c1_rd_gnt} !== {exp0, ~exp0})
                $display("FAIL contention_gnt[%0d]: got %b want %b", i, {c0_rd_gnt, c1_rd_gnt}, {exp0, ~exp0});
            else n_pass++;
            tick();
        end
        c0_rd_req = 1'b0; c1_rd_req = 1'b0;
        repeat (RESP + 2) tick();
        n_total++; if (c0_cyc_q.size() != e0.size()) $display("FAIL contention_c0_count: got %0d want %0d", c0_cyc_q.size(), e0.size()); else n_pass++;
        n_total++; if (c1_cyc_q.size() != e1.size()) $display("FAIL contention_c1_count: got %0d want %0d", c1_cyc_q.size(), e1.size()); else n_pass++;
        for (int i = 0; i < e0.size() && i < c0_cyc_q.size(); i++) begin
            n_total++;
            if (c0_cyc_q[i] != e0[i] || c0_dat_q[i] !== mv(10))
                $display("FAIL contention_c0_resp[%0d]: got cycle %0d data %h want cycle %0d data %h", i, c0_cyc_q[i], c0_dat_q[i], e0[i], mv(10));
            else n_pass++;
        end
        for (int i = 0; i < e1.size() && i < c1_cyc_q.size(); i++) begin
            n_total++;
            if (c1_cyc_q[i] != e1[i] || c1_dat_q[i] !== mv(20))
                $display("FAIL contention_c1_resp[%0d]: got cycle %0d data %h want cycle %0d data %h", i, c1_cyc_q[i], c1_dat_q[i], e1[i], mv(20));
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int t0, last_vld;
        clear_log();
        for (int i = 0; i < 16; i++) begin
            c1_rd_req = 1'b1; c1_rd_addr = AW'(i);
            #1;
            if (i == 0) t0 = cyc;
            n_total++;
            if ({c0_rd_gnt, c1_rd_gnt} !== 2'b01) $display("FAIL stream_gnt[%0d]: got %b want 01", i, {c0_rd_gnt, c1_rd_gnt});
            else n_pass++;
            tick();
        end
        c1_rd_req = 1'b0; c1_rd_addr = '0;
        last_vld = t0 + 15 + RESP;
        while (cyc < last_vld) tick();
        n_total++; if ({c1_rd_vld, idle} !== 2'b10) $display("FAIL stream_last_vld: got vld,idle=%b want 10", {c1_rd_vld, idle}); else n_pass++;
        tick();
        n_total++; if ({c1_rd_vld, idle} !== 2'b01) $display("FAIL stream_idle_after: got vld,idle=%b want 01", {c1_rd_vld, idle}); else n_pass++;
        n_total++; if (c1_cyc_q.size() != 16) $display("FAIL stream_count: got %0d want 16", c1_cyc_q.size()); else n_pass++;
        for (int i = 0; i < 16 && i < c1_cyc_q.size(); i++) begin
            n_total++;
            if (c1_cyc_q[i] != t0 + RESP + i || c1_dat_q[i] !== mv(i))
                $display("FAIL stream_resp[%0d]: got cycle %0d data %h want cycle %0d data %h", i, c1_cyc_q[i], c1_dat_q[i], t0 + RESP + i, mv(i));
            else n_pass++;
        end
        n_total++; if (c0_cyc_q.size() != 0) $display("FAIL stream_c0_quiet: got %0d pulses want 0", c0_cyc_q.size()); else n_pass++;
    endtask

    task automatic test_block();
        int ta, tb, tc;
        clear_log();
        c1_rd_req = 1'b1; c1_rd_addr = 13'd7;
        #1; ta = cyc;
        n_total++; if ({c0_rd_gnt, c1_rd_gnt} !== 2'b01) $display("FAIL block_pre_gnt: got %b want 01", {c0_rd_gnt, c1_rd_gnt}); else n_pass++;
        tick();
        // Both request under block: no grant and last_gnt must stay on client 1.
        rd_block = 1'b1;
        c0_rd_req = 1'b1; c0_rd_addr = 13'd3;
        c1_rd_addr = 13'd21;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++;
            if ({c0_rd_gnt, c1_rd_gnt} !== 2'b00) $display("FAIL block_gnt[%0d]: got %b want 00", i, {c0_rd_gnt, c1_rd_gnt});
            else n_pass++;
            if (i > 0) begin
                n_total++;
                if (mem_rd_en !== 1'b0) $display("FAIL block_mem_rd_en[%0d]: got %b want 0", i, mem_rd_en); else n_pass++;
            end
            tick();
        end
        rd_block = 1'b0;
        #1; tb = cyc;
        n_total++; if ({c0_rd_gnt, c1_rd_gnt} !== 2'b10) $display("FAIL block_release_gnt: got %b want 10", {c0_rd_gnt, c1_rd_gnt}); else n_pass++;
        tick();
        c0_rd_req = 1'b0;
        #1; tc = cyc;
        n_total++; if ({c0_rd_gnt, c1_rd_gnt} !== 2'b01) $display("FAIL block_c1_gnt: got %b want 01", {c0_rd_gnt, c1_rd_gnt}); else n_pass++;
        tick();
        c1_rd_req = 1'b0;
        while (cyc <= tc + RESP + 1) tick();
        n_total++;
        if (c1_cyc_q.size() != 2) $display("FAIL block_c1_count: got %0d want 2", c1_cyc_q.size());
        else if (c1_cyc_q[0] != ta + RESP || c1_dat_q[0] !== mv(7) || c1_cyc_q[1] != tc + RESP || c1_dat_q[1] !== mv(21))
            $display("FAIL block_c1_resp: got cycles %0d,%0d data %h,%h want cycles %0d,%0d", c1_cyc_q[0], c1_cyc_q[1], c1_dat_q[0], c1_dat_q[1], ta + RESP, tc + RESP);
        else n_pass++;
        n_total++;
        if (c0_cyc_q.size() != 1) $display("FAIL block_c0_count: got %0d want 1", c0_cyc_q.size());
        else if (c0_cyc_q[0] != tb + RESP || c0_dat_q[0] !== mv(3))
            $display("FAIL block_c0_resp: got cycle %0d data %h want cycle %0d data %h", c0_cyc_q[0], c0_dat_q[0], tb + RESP, mv(3));
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int t0, tr;
        clear_log();
        c0_rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            c0_rd_addr = AW'(i + 1);
            #1;
            if (i == 0) t0 = cyc;
            n_total++;
            if (c0_rd_gnt !== 1'b1) $display("FAIL rstmid_gnt[%0d]: got %b want 1", i, c0_rd_gnt); else n_pass++;
            tick();
        end
        c0_rd_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++; if ({mem_rd_en, idle} !== 2'b01) $display("FAIL rstmid_en_idle: got %b want 01", {mem_rd_en, idle}); else n_pass++;
        n_total++; if (mem_rd_addr !== '0) $display("FAIL rstmid_addr: got %h want 0", mem_rd_addr); else n_pass++;
        n_total++; if (c0_rd_data !== '0 || c1_rd_data !== '0) $display("FAIL rstmid_data: got %h,%h want 0,0", c0_rd_data, c1_rd_data); else n_pass++;
        while (cyc < t0 + 2 + RESP + 2) tick();
        n_total++;
        if (c0_cyc_q.size() + c1_cyc_q.size() != 0) $display("FAIL rstmid_no_vld: got %0d pulses want 0", c0_cyc_q.size() + c1_cyc_q.size());
        else n_pass++;
        c1_rd_req = 1'b1; c1_rd_addr = 13'd9;
        #1; tr = cyc;
        n_total++; if ({c0_rd_gnt, c1_rd_gnt} !== 2'b01) $display("FAIL rstmid_next_gnt: got %b want 01", {c0_rd_gnt, c1_rd_gnt}); else n_pass++;
        tick();
        c1_rd_req = 1'b0;
        repeat (RESP + 1) tick();
        n_total++;
        if (c1_cyc_q.size() != 1) $display("FAIL rstmid_next_count: got %0d want 1", c1_cyc_q.size());
        else if (c1_cyc_q[0] != tr + RESP || c1_dat_q[0] !== mv(9))
            $display("FAIL rstmid_next_resp: got cycle %0d data %h want cycle %0d data %h", c1_cyc_q[0], c1_dat_q[0], tr + RESP, mv(9));
        else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rd_block = 1'b0;
        c0_rd_req = 1'b1; c0_rd_addr = 13'd5;
        c1_rd_req = 1'b1; c1_rd_addr = 13'd9;
        tick();
        tick();
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_block();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uram_rd_arb.md
# uram_rd_arb

Two-client read arbiter and response router for one simple-dual-port URAM/BRAM read port (sdp_uram / sdp_bram). Grants one read per cycle to one of two requesters using round-robin, registers the winning address onto the memory read port, and tracks each in-flight read with a tag pipeline matched to the memory's fixed read latency. Returned data is steered to the issuing client. The memory write port is not touched by this block.

## Interface
- ADDR_WIDTH, 13: memory address width; must equal $clog2(DEPTH) of the attached memory.
- DATA_WIDTH, 72: memory data width.
- MEM_LATENCY, 4: cycles from mem_rd_en sampled high to mem_dout valid. Equals NUM_PIPE+1 of the attached memory. Legal range 1..32.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rd_block  in  1  when high, no grants are issued. In-flight reads still complete.
- c0_rd_req  in  1  client 0 read request. Held with a stable address until granted.
- c0_rd_addr  in  ADDR_WIDTH  client 0 read address.
- c0_rd_gnt  out  1  combinational grant. Request and address are consumed in the same cycle.
- c0_rd_vld  out  1  one-cycle pulse, c0_rd_data valid.
- c0_rd_data  out  DATA_WIDTH  client 0 read data.
- c1_rd_req, c1_rd_addr, c1_rd_gnt, c1_rd_vld, c1_rd_data: same meaning as the client 0 ports, for client 1.
- mem_rd_en  out  1  registered read enable to the memory.
- mem_rd_addr  out  ADDR_WIDTH  registered read address to the memory.
- mem_dout  in  DATA_WIDTH  memory read data.
- idle  out  1  high when no read is issued or in flight.

## Operation
Arbitration (combinational, per cycle):
- Grants are issued only when rd_block=0.
- Only one client requesting: that client is granted.
- Both clients requesting: the client opposite to last_gnt is granted.
- last_gnt (1 bit) updates to the granted id on every grant and holds otherwise.
- c0_rd_gnt and c1_rd_gnt are never high in the same cycle.
- Clients must not depend on gnt to drive req (no combinational loop).

Issue:
- On a grant, the next edge loads mem_rd_en=1 and mem_rd_addr = the granted client's address.
- With no grant: mem_rd_en=0 and mem_rd_addr holds its value.

Tag pipeline:
- Shift register of {valid, id}, MEM_LATENCY stages deep, fed from {mem_rd_en, issued id}.
- Its output is aligned with mem_dout.

Response:
- When the tag output is valid, the next edge registers mem_dout into the data register of client id and pulses that client's rd_vld for one cycle.
- The other client's data register holds its last value.
- Responses return in issue order and cannot be back-pressured. Clients must always accept rd_vld.

idle:
- Registered: idle = ~mem_rd_en & ~any tag stage valid & ~grant this cycle.

## Timing
- Grant at cycle T. mem_rd_en is high in T+1. mem_dout is valid in T+1+MEM_LATENCY. cN_rd_vld is high in T+2+MEM_LATENCY.
- Total latency, grant to vld: MEM_LATENCY+2 cycles.
- Throughput: one read per cycle, sustained. Back-to-back grants produce back-to-back vld pulses with no bubbles.
- Reset values:
  - mem_rd_en=0, mem_rd_addr=0.
  - All tag stages invalid.
  - c0/c1_rd_vld=0, c0/c1_rd_data=0.
  - last_gnt=1, so client 0 wins the first contention.
  - idle=1.
- Grants are suppressed while rst=1.
- Reset mid-operation: all in-flight tags are discarded and no vld is emitted for reads issued before reset. Memory contents are unaffected.
- rd_block asserted: takes effect the same cycle (gnt forced low). Deasserting it allows grants the same cycle.
- Simultaneous request and rd_block: no grant, last_gnt unchanged.

## Configuration
- Macro URAM_RD_ARB_FIXED_PRIO_EN.
- Defined: client 0 always wins contention and last_gnt is unused, so client 1 can starve.
- Undefined (default): round-robin as above.
- Latency, reset values and handshake are identical in both builds.

## Test plan
- Single read: memory preloaded with mem[5]=0xA5. c0 requests addr 5 at T, with MEM_LATENCY=4 -> c0_rd_gnt at T, mem_rd_en at T+1, c0_rd_vld with data 0xA5 at T+6, c1_rd_vld stays 0.
- Contention: both clients request continuously for 8 cycles after reset -> grants alternate c0,c1,c0,... and vld pulses alternate likewise at 6-cycle offset. Under URAM_RD_ARB_FIXED_PRIO_EN, all 8 grants go to c0.
- Streaming: c1 alone issues addrs 0..15 back-to-back -> 16 consecutive c1_rd_vld cycles with data mem[0..15] in order. idle returns to 1 one cycle after the last vld.
- Block: rd_block high for 3 cycles while c0 requests -> no gnt for 3 cycles, grant on the cycle rd_block drops, and an in-flight read issued before the block still returns.
- Reset mid-flight: 3 reads in flight, rst pulsed 1 cycle -> no vld pulses follow, outputs at reset values, and the next request after reset is serviced with normal latency.
